spi_transceiver: RTL and testbench
==================================

# spi_transceiver

Parametrised full-duplex SPI command/response engine for the SD card reader. It serialises a TX_BITS-wide command onto MOSI MSB-first, byte-aligned to the bus, then polls MISO for a response start bit (first 0) and shifts in an RX_BITS-wide response, with a bounded wait and timeout flag. It sits between the SD card controller FSM and the SPI pins, driven by the shared sclk edge strobes.

## Interface
- TX_BITS, 48: command width in bits, ≥1.
- RX_BITS, 8: response width in bits, including the start bit, 1..64.
- WAIT_BITS, 64: maximum sclk rising edges polled in WAIT before timeout, ≥1.
- BYTE_ALIGN, 1: 1 = command starts only at a byte boundary; 0 = start immediately.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- sclk_posedge  in  1  one-clk strobe marking the SPI clock rising edge (sample point).
- sclk_negedge  in  1  one-clk strobe marking the SPI clock falling edge (shift point).
- start  in  1  begin a transaction; sampled only in IDLE.
- tx_data  in  TX_BITS  command, latched on accepted start.
- miso  in  1  serial data from the card.
- mosi  out  1  serial data to the card, registered; idles high.
- rx_data  out  RX_BITS  last response, MSB = start bit.
- rx_valid  out  1  one-clk pulse when rx_data is updated by a good response.
- timeout  out  1  one-clk pulse when WAIT expires.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  combinational: state == IDLE && !start.

## Operation
- bit_phase: 3-bit free-running counter; decrements (wraps 0→7) on every sclk_negedge, in every state. Value 7 means the next bit is a byte MSB.
- IDLE: mosi=1. On start, latch tx_data, set tx_index=TX_BITS-1, and go to SYNC (BYTE_ALIGN=1) or SEND (BYTE_ALIGN=0).
- SYNC: mosi=1. On any cycle with bit_phase==7 and no sclk_negedge, go to SEND.
- SEND: mosi=tx[tx_index]. On sclk_negedge, go to WAIT with poll_cnt=0 if tx_index==0; otherwise decrement tx_index. The last bit therefore stays on the bus for a full sclk period.
- WAIT: mosi=1. On sclk_posedge, sample miso:
  - If miso==0, load rx_shift=0 and rx_cnt=1. If RX_BITS==1, finish; otherwise go to RECV.
  - If miso==1 and poll_cnt+1==WAIT_BITS, set rx_data to all ones, pulse timeout, and go to IDLE.
  - Otherwise increment poll_cnt.
- RECV: mosi=1. On sclk_posedge, rx_shift={rx_shift[RX_BITS-2:0],miso} and rx_cnt increments. When rx_cnt reaches RX_BITS, finish.
- Finish: rx_data<=final shift value, pulse rx_valid, go to IDLE.
- Counter widths: tx_index $clog2(TX_BITS); poll_cnt $clog2(WAIT_BITS+1); rx_cnt $clog2(RX_BITS+1). No counter may overflow.
- start while busy is ignored; tx_data changes after acceptance have no effect.
- If sclk_posedge and sclk_negedge are both asserted, each is processed by its own rules in the same cycle.

## Timing
- Reset values: state IDLE, bit_phase 7, mosi 1, rx_data all ones, rx_valid 0, timeout 0, busy 0, done 1 (with start low).
- Reset mid-transaction aborts within one clk. No rx_valid or timeout pulse is produced.
- start→busy: 1 clk.
- With BYTE_ALIGN=0, mosi carries tx MSB from the 2nd clk after start.
- With BYTE_ALIGN=1, mosi carries tx MSB 1 clk after the first cycle with bit_phase==7 following start.
- Each command bit spans exactly one sclk period, from negedge to negedge. The command occupies TX_BITS negedges.
- rx_valid and timeout are mutually exclusive. Each asserts on the clk after the deciding sclk_posedge, in the same clk that busy falls.
- Strobe spacing must be ≥2 clk.

## Test plan
- CMD0: tx_data=48'h400000000095, BYTE_ALIGN=1; MISO returns bytes FF,01. Required: mosi shows exactly 40 00 00 00 00 95, MSB-first, byte-aligned; rx_data=8'h01; one rx_valid pulse; done returns high.
- CMD8 R7: RX_BITS=40; MISO returns FF then 01 00 00 01 AA. Required: rx_data=40'h01000001AA; timeout stays 0.
- Timeout: WAIT_BITS=64, miso held 1. Required: timeout pulses on the clk after the 64th posedge in WAIT; rx_data=all ones; no rx_valid.
- Alignment: start asserted while bit_phase=3, BYTE_ALIGN=1. Required: mosi stays 1 for the 4 remaining bits, then the MSB appears. With BYTE_ALIGN=0, the MSB appears 2 clk after start.
- Ignored start: a second start with different tx_data pulsed mid-SEND. Required: the shifted bits are unchanged from the first command.
- Reset mid-RECV, after 3 response bits. Required: the next clk shows mosi=1, busy=0, rx_data=all ones, and no rx_valid pulse.

Source files
------------

// File: rtl/spi_transceiver.sv
// SPI command/response engine: shifts a command out MSB-first (optionally byte-aligned),
// then polls MISO for a response start bit and shifts in a fixed-width response.
module spi_transceiver #(
  parameter int TX_BITS    = 48,
  parameter int RX_BITS    = 8,
  parameter int WAIT_BITS  = 64,
  parameter bit BYTE_ALIGN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk_posedge,
  input  logic               sclk_negedge,
  input  logic               start,
  input  logic [TX_BITS-1:0] tx_data,
  input  logic               miso,
  output logic               mosi,
  output logic [RX_BITS-1:0] rx_data,
  output logic               rx_valid,
  output logic               timeout,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_dbg
);
  localparam int TX_IDX_W = (TX_BITS > 1) ? $clog2(TX_BITS) : 1;
  localparam int POLL_W   = $clog2(WAIT_BITS + 1);
  localparam int RX_CNT_W = $clog2(RX_BITS + 1);
  localparam logic [TX_IDX_W-1:0] TX_MSB_IDX = TX_IDX_W'(TX_BITS - 1);
  localparam logic [POLL_W-1:0]   POLL_LAST  = POLL_W'(WAIT_BITS - 1);
  localparam logic [RX_CNT_W-1:0] RX_LAST    = RX_CNT_W'(RX_BITS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_SEND, ST_WAIT, ST_RECV} state_t;

  state_t              state, state_d;
  logic [2:0]          bit_phase, bit_phase_d;
  logic [TX_BITS-1:0]  tx_reg, tx_reg_d;
  logic [TX_IDX_W-1:0] tx_index, tx_index_d;
  logic [POLL_W-1:0]   poll_cnt, poll_cnt_d;
  logic [RX_CNT_W-1:0] rx_cnt, rx_cnt_d;
  logic [RX_BITS-1:0]  rx_shift, rx_shift_d, rx_data_d;
  logic [RX_BITS:0]    rx_cat;
  logic                rx_valid_d, timeout_d, mosi_d;

  // Handshake: start is a request taken only in IDLE (done high means it will be taken);
  // busy is high from the clk after acceptance until the clk rx_valid/timeout pulses.
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_IDLE) && !start;
  assign state_dbg = state;
  assign rx_cat    = {rx_shift, miso};

  always_comb begin
    state_d     = state;
    bit_phase_d = sclk_negedge ? bit_phase - 3'd1 : bit_phase;
    tx_reg_d    = tx_reg;
    tx_index_d  = tx_index;
    poll_cnt_d  = poll_cnt;
    rx_cnt_d    = rx_cnt;
    rx_shift_d  = rx_shift;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    timeout_d   = 1'b0;
    mosi_d      = 1'b1;
    case (state)
      ST_IDLE: begin
        if (start) begin
          tx_reg_d   = tx_data;
          tx_index_d = TX_MSB_IDX;
          state_d    = BYTE_ALIGN ? ST_SYNC : ST_SEND;
        end
      end
      ST_SYNC: begin
        // Present the MSB as SEND is entered so it spans a whole sclk period.
        if (bit_phase == 3'd7 && !sclk_negedge) begin
          state_d = ST_SEND;
          mosi_d  = tx_reg[TX_BITS-1];
        end
      end
      ST_SEND: begin
        mosi_d = tx_reg[tx_index];
        if (sclk_negedge) begin
          if (tx_index == '0) begin
            state_d    = ST_WAIT;
            poll_cnt_d = '0;
          end else begin
            tx_index_d = tx_index - TX_IDX_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (sclk_posedge) begin
          if (!miso) begin
            rx_shift_d = '0;
            rx_cnt_d   = RX_CNT_W'(1);
            if (RX_BITS == 1) begin
              rx_data_d  = '0;
              rx_valid_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_RECV;
            end
          end else if (poll_cnt == POLL_LAST) begin
            rx_data_d = '1;
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            poll_cnt_d = poll_cnt + POLL_W'(1);
          end
        end
      end
      ST_RECV: begin
        if (sclk_posedge) begin
          rx_shift_d = rx_cat[RX_BITS-1:0];
          rx_cnt_d   = rx_cnt + RX_CNT_W'(1);
          if (rx_cnt == RX_LAST) begin
            rx_data_d  = rx_cat[RX_BITS-1:0];
            rx_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_phase <= 3'd7;
      tx_reg    <= '0;
      tx_index  <= '0;
      poll_cnt  <= '0;
      rx_cnt    <= '0;
      rx_shift  <= '0;
      rx_data   <= '1;
      rx_valid  <= 1'b0;
      timeout   <= 1'b0;
      mosi      <= 1'b1;
    end else begin
      state     <= state_d;
      bit_phase <= bit_phase_d;
      tx_reg    <= tx_reg_d;
      tx_index  <= tx_index_d;
      poll_cnt  <= poll_cnt_d;
      rx_cnt    <= rx_cnt_d;
      rx_shift  <= rx_shift_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      timeout   <= timeout_d;
      mosi      <= mosi_d;
    end
  end
endmodule

// File: tb/tb_spi_transceiver.sv
// Directed bench for spi_transceiver: three instances (default, 40-bit response, no byte align)
// share the sclk strobes and a card model that shifts staged bits onto miso at each falling edge.
module tb_spi_transceiver;
  logic        clk;
  logic        reset;
  logic        sclk_posedge, sclk_negedge;
  logic [47:0] tx_data;
  logic        miso;
  logic        start_a [3];
  logic        mosi_a [3], rx_valid_a [3], timeout_a [3], busy_a [3], done_a [3];
  logic [2:0]  state_a [3];
  logic [7:0]  rx_data0, rx_data2;
  logic [39:0] rx_data1;
  int          checks = 0;
  int          errors = 0;

  localparam logic [47:0] CMD0 = 48'h400000000095;
  localparam logic [47:0] CMD8 = 48'h48000001AA87;
  localparam logic [47:0] CMDA = 48'h5A3C00FF0187;
  localparam logic [47:0] CMDB = 48'h7E5500AA33C1;
  localparam logic [47:0] CMDX = 48'h81AAFF55CC3E;

  spi_transceiver #(.TX_BITS(48), .RX_BITS(8), .WAIT_BITS(64), .BYTE_ALIGN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
    .start(start_a[0]), .tx_data(tx_data), .miso(miso), .mosi(mosi_a[0]), .rx_data(rx_data0),
    .rx_valid(rx_valid_a[0]), .timeout(timeout_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .state_dbg(state_a[0]));

  spi_transceiver #(.TX_BITS(48), .RX_BITS(40), .WAIT_BITS(64), .BYTE_ALIGN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
    .start(start_a[1]), .tx_data(tx_data), .miso(miso), .mosi(mosi_a[1]), .rx_data(rx_data1),
    .rx_valid(rx_valid_a[1]), .timeout(timeout_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .state_dbg(state_a[1]));

  spi_transceiver #(.TX_BITS(48), .RX_BITS(8), .WAIT_BITS(64), .BYTE_ALIGN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
    .start(start_a[2]), .tx_data(tx_data), .miso(miso), .mosi(mosi_a[2]), .rx_data(rx_data2),
    .rx_valid(rx_valid_a[2]), .timeout(timeout_a[2]), .busy(busy_a[2]), .done(done_a[2]),
    .state_dbg(state_a[2]));

  // ---------------- clock / reset / strobes ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int strobe_cnt = 0;
  initial begin
    sclk_posedge = 1'b0;
    sclk_negedge = 1'b0;
    forever begin
      @(posedge clk); #1;
      strobe_cnt++;
      sclk_negedge = (strobe_cnt % 8 == 0);
      sclk_posedge = (strobe_cnt % 8 == 4);
    end
  end

  // Reference bit_phase, used only to choose when to issue start.
  logic [2:0] model_phase;
  always @(posedge clk) begin
    if (reset) model_phase <= 3'd7;
    else if (sclk_negedge) model_phase <= model_phase - 3'd1;
  end

  // Card model: new miso bit on every sclk falling edge, idle high.
  logic card_q [$];
  logic stage_q [$];
  initial begin
    miso = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (sclk_negedge) miso = (card_q.size() > 0) ? card_q.pop_front() : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  logic mosi_log [0:2047];
  logic busy_log [0:2047];
  logic bits_q [$];
  int   valid_cnt, timeout_cnt, valid_k, timeout_k, end_k;

  task automatic stage_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) stage_q.push_back(b[i]);
  endtask

  // Starts a transaction on instance sel one clk after the falling edge that takes bit_phase
  // to 3 (start cycle s), then logs from s+1 (k=1) until busy has been low for a few clks.
  task automatic run_txn(input int sel, input logic [47:0] cmd, input logic [47:0] alt_cmd,
                         input int inject_k, input int reset_k);
    int k;
    int tail;
    bits_q.delete();
    valid_cnt = 0; timeout_cnt = 0; valid_k = -1; timeout_k = -1; end_k = -1;
    for (int i = 0; i < 2048; i++) begin
      mosi_log[i] = 1'bx;
      busy_log[i] = 1'bx;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(sclk_negedge && model_phase == 3'd4) && k < 200);
    card_q.delete();
    for (int i = 0; i < 52; i++) card_q.push_back(1'b1);
    foreach (stage_q[i]) card_q.push_back(stage_q[i]);
    stage_q.delete();
    @(posedge clk); #1;
    start_a[sel] = 1'b1;
    tx_data = cmd;
    @(posedge clk); #1;
    start_a[sel] = 1'b0;
    k = 0;
    tail = 0;
    while (k < 1500 && tail < 4) begin
      @(negedge clk);
      k++;
      mosi_log[k] = mosi_a[sel];
      busy_log[k] = busy_a[sel];
      if (sclk_posedge && busy_a[sel]) bits_q.push_back(mosi_a[sel]);
      if (rx_valid_a[sel]) begin valid_cnt++; valid_k = k; end
      if (timeout_a[sel]) begin timeout_cnt++; timeout_k = k; end
      if (end_k < 0 && !busy_a[sel]) end_k = k;
      if (end_k >= 0) tail++;
      if (k == inject_k) begin start_a[sel] = 1'b1; tx_data = alt_cmd; end
      if (k == inject_k + 1) start_a[sel] = 1'b0;
      if (k == reset_k) reset = 1'b1;
      if (k == reset_k + 2) reset = 1'b0;
    end
    checks++;
    if (end_k < 0) begin
      errors++;
      $display("FAIL txn_end: busy still high after %0d clks, required to fall", k);
    end
  endtask

  function automatic logic [47:0] bits_at(input int first);
    logic [47:0] v;
    for (int i = 0; i < 48; i++) v[47-i] = (first + i < bits_q.size()) ? bits_q[first+i] : 1'bx;
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
    tx_data = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (mosi_a[0] !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %b want 1", mosi_a[0]); end
    checks++; if (rx_data0 !== 8'hFF) begin errors++; $display("FAIL reset_rx_data: got %h want ff", rx_data0); end
    checks++; if (rx_data1 !== 40'hFFFFFFFFFF) begin errors++; $display("FAIL reset_rx_data40: got %h want all ones", rx_data1); end
    checks++; if (rx_valid_a[0] !== 1'b0 || timeout_a[0] !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: rx_valid %b timeout %b want 0 0", rx_valid_a[0], timeout_a[0]);
    end
    checks++; if (busy_a[0] !== 1'b0 || done_a[0] !== 1'b1) begin
      errors++; $display("FAIL reset_busy_done: busy %b done %b want 0 1", busy_a[0], done_a[0]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy_a[2] !== 1'b0 || done_a[2] !== 1'b1 || mosi_a[2] !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset: busy %b done %b mosi %b want 0 1 1", busy_a[2], done_a[2], mosi_a[2]);
    end
  endtask

  task automatic test_cmd0();
    stage_byte(8'hFF);
    stage_byte(8'h01);
    run_txn(0, CMD0, CMD0, -10, -10);
    checks++; if (busy_log[1] !== 1'b1) begin errors++; $display("FAIL cmd0_busy_latency: got %b want 1", busy_log[1]); end
    checks++; if (bits_q.size() < 52 || {bits_q[0], bits_q[1], bits_q[2], bits_q[3]} !== 4'b1111) begin
      errors++; $display("FAIL cmd0_lead_ones: %0d samples, want 4 idle ones first", bits_q.size());
    end
    checks++; if (bits_at(4) !== CMD0) begin errors++; $display("FAIL cmd0_mosi: got %h want %h", bits_at(4), CMD0); end
    checks++; if (valid_cnt !== 1 || valid_k !== 548) begin
      errors++; $display("FAIL cmd0_rx_valid: %0d pulses at k=%0d, want 1 at k=548", valid_cnt, valid_k);
    end
    checks++; if (rx_data0 !== 8'h01) begin errors++; $display("FAIL cmd0_rx_data: got %h want 01", rx_data0); end
    checks++; if (end_k !== valid_k || timeout_cnt !== 0) begin
      errors++; $display("FAIL cmd0_busy_fall: busy fell k=%0d, valid k=%0d, timeouts %0d", end_k, valid_k, timeout_cnt);
    end
    checks++; if (done_a[0] !== 1'b1) begin errors++; $display("FAIL cmd0_done: got %b want 1", done_a[0]); end
  endtask

  task automatic test_alignment();
    int early;
    stage_byte(8'hFF);
    stage_byte(8'h01);
    run_txn(0, CMDA, CMDA, -10, -10);
    early = 0;
    for (int k = 1; k <= 32; k++) if (mosi_log[k] !== 1'b1) early++;
    checks++; if (early != 0) begin errors++; $display("FAIL align_idle: %0d non-one clks before MSB, want 0", early); end
    checks++; if (mosi_log[33] !== 1'b0 || mosi_log[40] !== 1'b0) begin
      errors++; $display("FAIL align_msb: k33 %b k40 %b want 0 0", mosi_log[33], mosi_log[40]);
    end
    checks++; if (mosi_log[41] !== 1'b1) begin errors++; $display("FAIL align_bit46: got %b want 1", mosi_log[41]); end
    stage_byte(8'hFF);
    stage_byte(8'h01);
    run_txn(2, CMDA, CMDA, -10, -10);
    checks++; if (mosi_log[1] !== 1'b1 || mosi_log[2] !== 1'b0) begin
      errors++; $display("FAIL noalign_msb: k1 %b k2 %b want 1 0", mosi_log[1], mosi_log[2]);
    end
    checks++; if (bits_at(0) !== CMDA) begin errors++; $display("FAIL noalign_mosi: got %h want %h", bits_at(0), CMDA); end
    checks++; if (valid_cnt !== 1 || rx_data2 !== 8'h01) begin
      errors++; $display("FAIL noalign_rx: %0d pulses rx_data %h want 1 01", valid_cnt, rx_data2);
    end
  endtask

  task automatic test_cmd8_r7();
    stage_byte(8'hFF);
    stage_byte(8'h01); stage_byte(8'h00); stage_byte(8'h00); stage_byte(8'h01); stage_byte(8'hAA);
    run_txn(1, CMD8, CMD8, -10, -10);
    checks++; if (bits_at(4) !== CMD8) begin errors++; $display("FAIL r7_mosi: got %h want %h", bits_at(4), CMD8); end
    checks++; if (rx_data1 !== 40'h01000001AA) begin errors++; $display("FAIL r7_rx_data: got %h want 01000001aa", rx_data1); end
    checks++; if (valid_cnt !== 1 || timeout_cnt !== 0 || end_k !== valid_k) begin
      errors++; $display("FAIL r7_pulses: valid %0d timeout %0d end %0d valid_k %0d", valid_cnt, timeout_cnt, end_k, valid_k);
    end
  endtask

  task automatic test_timeout();
    run_txn(0, CMD0, CMD0, -10, -10);
    checks++; if (timeout_cnt !== 1 || timeout_k !== 924) begin
      errors++; $display("FAIL timeout_pulse: %0d pulses at k=%0d, want 1 at k=924", timeout_cnt, timeout_k);
    end
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL timeout_no_valid: got %0d pulses want 0", valid_cnt); end
    checks++; if (rx_data0 !== 8'hFF) begin errors++; $display("FAIL timeout_rx_data: got %h want ff", rx_data0); end
    checks++; if (end_k !== timeout_k) begin errors++; $display("FAIL timeout_busy_fall: k=%0d want %0d", end_k, timeout_k); end
  endtask

  task automatic test_ignored_start();
    stage_byte(8'hFF);
    stage_byte(8'h01);
    run_txn(0, CMDB, CMDX, 100, -10);
    checks++; if (bits_at(4) !== CMDB) begin errors++; $display("FAIL ignored_start_mosi: got %h want %h", bits_at(4), CMDB); end
    checks++; if (valid_cnt !== 1 || valid_k !== 548) begin
      errors++; $display("FAIL ignored_start_valid: %0d pulses at k=%0d want 1 at 548", valid_cnt, valid_k);
    end
    checks++; if (rx_data0 !== 8'h01) begin errors++; $display("FAIL ignored_start_rx: got %h want 01", rx_data0); end
  endtask

  task automatic test_reset_mid_recv();
    stage_byte(8'hFF);
    stage_byte(8'h00);
    run_txn(0, CMD0, CMD0, -10, 510);
    checks++; if (busy_log[510] !== 1'b1) begin errors++; $display("FAIL midrecv_busy_before: got %b want 1", busy_log[510]); end
    checks++; if (mosi_log[511] !== 1'b1 || busy_log[511] !== 1'b0) begin
      errors++; $display("FAIL midrecv_abort: mosi %b busy %b want 1 0", mosi_log[511], busy_log[511]);
    end
    checks++; if (rx_data0 !== 8'hFF) begin errors++; $display("FAIL midrecv_rx_data: got %h want ff", rx_data0); end
    checks++; if (valid_cnt !== 0 || timeout_cnt !== 0) begin
      errors++; $display("FAIL midrecv_pulses: valid %0d timeout %0d want 0 0", valid_cnt, timeout_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
    tx_data = '0;
    test_reset();
    test_cmd0();
    test_alignment();
    test_cmd8_r7();
    test_timeout();
    test_ignored_start();
    test_reset_mid_recv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
